// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: md_op encodings, controller
// state encodings and the combinational arithmetic used at the start edge.
package mdu_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam logic [0:0] MDU_IDLE = 1'b0;
  localparam logic [0:0] MDU_RUN  = 1'b1;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } md_result_t;

  // A 64-bit product of the sign- or zero-extended operands is exact modulo 2^64.
  function automatic md_result_t md_mul(input logic [31:0] a, input logic [31:0] b,
                                        input logic is_signed);
    logic [63:0] ax;
    logic [63:0] bx;
    logic [63:0] p;
    ax = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
    bx = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ax * bx;
    return '{hi: p[63:32], lo: p[31:0]};
  endfunction

  // Signed division on magnitudes; 0x80000000 / -1 falls out as LO=0x80000000, HI=0.
  function automatic md_result_t md_div(input logic [31:0] a, input logic [31:0] b,
                                        input logic is_signed);
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] q;
    logic [31:0] r;
    neg_a = is_signed & a[31];
    neg_b = is_signed & b[31];
    mag_a = neg_a ? (~a + 32'd1) : a;
    mag_b = neg_b ? (~b + 32'd1) : b;
    q = 32'd0;
    r = 32'd0;
    if (mag_b != 32'd0) begin
      q = mag_a / mag_b;
      r = mag_a % mag_b;
    end
    return '{hi: neg_a ? (~r + 32'd1) : r,
             lo: (neg_a ^ neg_b) ? (~q + 32'd1) : q};
  endfunction

endpackage

// File: rtl/mdu_counter.sv
// Down-counter for the MDU busy window: loads a cycle count, decrements to
// zero and flags the last busy cycle.
module mdu_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == W'(1));

endmodule

// File: rtl/mdu.sv
// E-stage multiply/divide unit: results are computed at the start edge, held as
// pending, and committed to HI/LO after a fixed busy window.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] rs_out,
  input  logic [31:0] rt_out,
  input  logic [2:0]  md_op,
  input  logic        start,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [0:0]  state_q,   state_d;
  logic [31:0] hi_q,      hi_d;
  logic [31:0] lo_q,      lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_ok_q, pend_ok_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_done;
  md_result_t       mul_res;
  md_result_t       div_res;

  mdu_counter #(.W(CNT_W)) u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .done     (cnt_done)
  );

  // NOTE: every always_comb output is defaulted first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    pend_hi_d    = pend_hi_q;
    pend_lo_d    = pend_lo_q;
    pend_ok_d    = pend_ok_q;
    cnt_load     = 1'b0;
    cnt_load_val = CNT_W'(DIV_CYCLES);
    mul_res      = md_mul(rs_out, rt_out, md_op == MD_MULT);
    div_res      = md_div(rs_out, rt_out, md_op == MD_DIV);

    if (state_q == MDU_IDLE) begin
      if (start) begin
        case (md_op)
          MD_MULT, MD_MULTU: begin
            pend_hi_d    = mul_res.hi;
            pend_lo_d    = mul_res.lo;
            pend_ok_d    = 1'b1;
            cnt_load     = 1'b1;
            cnt_load_val = CNT_W'(MULT_CYCLES);
            state_d      = MDU_RUN;
          end
          MD_DIV, MD_DIVU: begin
            pend_hi_d    = div_res.hi;
            pend_lo_d    = div_res.lo;
            pend_ok_d    = (rt_out != 32'd0);
            cnt_load     = 1'b1;
            cnt_load_val = CNT_W'(DIV_CYCLES);
            state_d      = MDU_RUN;
          end
          MD_MTHI: hi_d = rs_out;
          MD_MTLO: lo_d = rs_out;
          default: ;
        endcase
      end
    end else if (cnt_done) begin
      // Divide-by-zero runs the full window but leaves HI/LO untouched.
      state_d = MDU_IDLE;
      if (pend_ok_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MDU_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_ok_q <= pend_ok_d;
    end
  end

  assign busy   = (state_q == MDU_RUN);
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: a cycle-level behavioural model built on plain
// 64-bit arithmetic, a per-cycle compare process, and directed literal checks.
module tb_mdu;
  import mdu_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic [31:0] rs_out;
  logic [31:0] rt_out;
  logic [2:0]  md_op;
  logic        start;
  logic        busy;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk    (clk),
    .reset  (reset),
    .rs_out (rs_out),
    .rt_out (rt_out),
    .md_op  (md_op),
    .start  (start),
    .busy   (busy),
    .hi_out (hi_out),
    .lo_out (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: remaining busy cycles plus the result to commit when they run out.
  int          m_left = 0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic [31:0] m_phi  = '0;
  logic [31:0] m_plo  = '0;
  bit          m_pok  = 1'b0;

  always @(posedge clk) begin
    longint      sa;
    longint      sb;
    logic [63:0] prod;
    logic [63:0] uq;
    logic [63:0] ur;
    if (reset) begin
      m_left = 0;
      m_hi   = '0;
      m_lo   = '0;
      m_pok  = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_pok) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (start) begin
      sa = $signed(rs_out);
      sb = $signed(rt_out);
      case (md_op)
        MD_MULT: begin
          prod = 64'(sa * sb);
          {m_phi, m_plo} = prod;
          m_pok = 1'b1; m_left = MULT_N;
        end
        MD_MULTU: begin
          prod = {32'd0, rs_out} * {32'd0, rt_out};
          {m_phi, m_plo} = prod;
          m_pok = 1'b1; m_left = MULT_N;
        end
        MD_DIV: begin
          m_pok = (rt_out != 0); m_left = DIV_N;
          if (m_pok) begin
            m_plo = 32'(sa / sb);
            m_phi = 32'(sa % sb);
          end
        end
        MD_DIVU: begin
          m_pok = (rt_out != 0); m_left = DIV_N;
          if (m_pok) begin
            uq = {32'd0, rs_out} / {32'd0, rt_out};
            ur = {32'd0, rs_out} % {32'd0, rt_out};
            m_plo = uq[31:0];
            m_phi = ur[31:0];
          end
        end
        MD_MTHI: m_hi = rs_out;
        MD_MTLO: m_lo = rs_out;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_busy", {31'd0, busy}, {31'd0, (m_left > 0)});
      check("cyc_hi", hi_out, m_hi);
      check("cyc_lo", lo_out, m_lo);
    end
  end

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op, then count busy cycles while scrambling operands; optionally
  // pulse start with poke_op on busy cycle poke_at.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int poke_at, input logic [2:0] poke_op, output int cyc);
    md_op  = op;
    rs_out = a;
    rt_out = b;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    md_op = MD_NONE;
    cyc   = 0;
    while (busy && cyc < 100) begin
      cyc++;
      rs_out = $urandom;
      rt_out = $urandom;
      if (cyc == poke_at) begin
        md_op = poke_op;
        start = 1'b1;
      end else begin
        md_op = MD_NONE;
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    md_op = MD_NONE;
    if (cyc >= 100) check("busy_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cyc;
    reset  = 1'b1;
    rs_out = '0;
    rt_out = '0;
    md_op  = MD_NONE;
    start  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi_out, 32'd0);
    check("reset_lo", lo_out, 32'd0);

    run_op(MD_MULT, 32'hFFFF_FFFF, 32'd4, -1, MD_NONE, cyc);
    check("mult_cycles", cyc, MULT_N);
    check("mult_hi", hi_out, 32'hFFFF_FFFF);
    check("mult_lo", lo_out, 32'hFFFF_FFFC);

    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd4, -1, MD_NONE, cyc);
    check("multu_hi", hi_out, 32'h0000_0003);
    check("multu_lo", lo_out, 32'hFFFF_FFFC);

    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, -1, MD_NONE, cyc);
    check("div_cycles", cyc, DIV_N);
    check("div_lo", lo_out, 32'hFFFF_FFFD);
    check("div_hi", hi_out, 32'hFFFF_FFFF);

    run_op(MD_DIVU, 32'd7, 32'd2, -1, MD_NONE, cyc);
    check("divu_lo", lo_out, 32'd3);
    check("divu_hi", hi_out, 32'd1);

    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, MD_NONE, cyc);
    check("divovf_lo", lo_out, 32'h8000_0000);
    check("divovf_hi", hi_out, 32'd0);

    // Back-to-back mthi/mtlo: each lands at its own edge, busy stays low.
    md_op = MD_MTHI; rs_out = 32'h1234_5678; start = 1'b1;
    @(negedge clk);
    check("mthi_hi", hi_out, 32'h1234_5678);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    md_op = MD_MTLO; rs_out = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0; md_op = MD_NONE;
    check("mtlo_lo", lo_out, 32'h9ABC_DEF0);
    check("mtlo_hi", hi_out, 32'h1234_5678);
    check("mtlo_busy", {31'd0, busy}, 32'd0);

    run_op(MD_MTHI, 32'd5, 32'd0, -1, MD_NONE, cyc);
    run_op(MD_MTLO, 32'd6, 32'd0, -1, MD_NONE, cyc);
    run_op(MD_DIV, 32'd100, 32'd0, -1, MD_NONE, cyc);
    check("div0_cycles", cyc, DIV_N);
    check("div0_hi", hi_out, 32'd5);
    check("div0_lo", lo_out, 32'd6);

    run_op(MD_DIVU, 32'd7, 32'd2, 4, MD_MULT, cyc);
    check("poke_cycles", cyc, DIV_N);
    check("poke_lo", lo_out, 32'd3);
    check("poke_hi", hi_out, 32'd1);
    run_op(MD_MULTU, 32'd9, 32'd9, 2, MD_MTHI, cyc);
    check("poke2_hi", hi_out, 32'd0);
    check("poke2_lo", lo_out, 32'd81);

    // Reset during the third busy cycle abandons the multiply.
    md_op = MD_MULT; rs_out = 32'd3; rt_out = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0; md_op = MD_NONE;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi_out, 32'd0);
    check("rst_lo", lo_out, 32'd0);
    repeat (8) @(negedge clk);
    check("rst_late_hi", hi_out, 32'd0);
    check("rst_late_lo", lo_out, 32'd0);

    // Reset and start together: reset wins.
    md_op = MD_MTHI; rs_out = 32'hCAFE_F00D; start = 1'b1; reset = 1'b1;
    @(negedge clk);
    start = 1'b0; reset = 1'b0; md_op = MD_NONE;
    check("rst_start_hi", hi_out, 32'd0);

    for (int i = 0; i < 250; i++) begin
      run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
             $urandom_range(0, 12), 3'($urandom_range(0, 7)), cyc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
